// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Reset release sequencer that sits directly after the reset synchronizer.
// After init_ni rises it releases NumDomains downstream reset domains one at
// a time, DelayCycles apart, starting with bit 0. A software warm reset with a
// 4-phase req/ack handshake puts every domain back into reset, holds them for
// HoldCycles and then repeats the release sequence. A test-mode bypass drives
// every domain reset straight from rst_ni.
//
// Optional build macro: RST_SEQUENCER_REVERSE_ASSERT_EN
//   When defined, a software reset asserts the domains in reverse order
//   (highest first, DelayCycles apart) before the hold phase. When undefined,
//   all domains assert together on the accepting edge.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   async active-low reset (synchronizer's rst_no)
//   init_ni      in   synchronized init; 0 holds all domains in reset
//   test_mode_i  in   1 = every rst_no bit follows rst_ni combinationally
//   sw_rst_req_i in   software warm-reset request (level, 4-phase)
//   sw_rst_ack_o out  software warm-reset acknowledge
//   rst_no       out  per-domain active-low resets, bit 0 released first
//   done_o       out  all domains released, sequencer running
// -----------------------------------------------------------------------------
module rst_sequencer #(
   parameter int NumDomains  = 4,
   parameter int DelayCycles = 8,
   parameter int HoldCycles  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_ni,
   input  logic                  test_mode_i,
   input  logic                  sw_rst_req_i,
   output logic                  sw_rst_ack_o,
   output logic [NumDomains-1:0] rst_no,
   output logic                  done_o
);

   localparam int MaxCnt = (DelayCycles > HoldCycles) ? DelayCycles : HoldCycles;
   localparam int CntW   = $clog2(MaxCnt + 1);
   localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

   localparam logic [CntW-1:0] CntZero   = {CntW{1'b0}};
   localparam logic [CntW-1:0] CntOne    = CntW'(32'd1);
   localparam logic [CntW-1:0] DelayLast = CntW'(DelayCycles - 1);
   localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
   localparam logic [IdxW-1:0] IdxZero   = {IdxW{1'b0}};
   localparam logic [IdxW-1:0] IdxOne    = IdxW'(32'd1);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumDomains - 1);
`ifdef RST_SEQUENCER_REVERSE_ASSERT_EN
   // Domain asserted right after the top one during a reverse sweep.
   localparam logic [IdxW-1:0] IdxBelowTop = IdxW'((NumDomains > 1) ? (NumDomains - 2) : 0);
`endif

   typedef enum logic [2:0] {
      ST_WAIT_INIT = 3'd0,
      ST_RELEASE   = 3'd1,
      ST_RUN       = 3'd2,
      ST_SW_HOLD   = 3'd3,
`ifdef RST_SEQUENCER_REVERSE_ASSERT_EN
      ST_SW_ASSERT = 3'd5,
`endif
      ST_SW_ACK    = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q,   cnt_d;
   logic [IdxW-1:0]         idx_q,   idx_d;
   logic [NumDomains-1:0]   rst_q,   rst_d;
   logic                    ack_q,   ack_d;
   logic                    done_q,  done_d;

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ack_d   = ack_q;
      done_d  = done_q;

      // A dropped init wins over everything, including a pending request.
      if ((state_q != ST_WAIT_INIT) && !init_ni) begin
         state_d = ST_WAIT_INIT;
         cnt_d   = CntZero;
         idx_d   = IdxZero;
         rst_d   = {NumDomains{1'b0}};
         ack_d   = 1'b0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT_INIT: begin
               if (init_ni) begin
                  state_d = ST_RELEASE;
                  cnt_d   = CntZero;
                  idx_d   = IdxZero;
               end else begin
                  state_d = ST_WAIT_INIT;
               end
            end

            ST_RELEASE: begin
               if (cnt_q == DelayLast) begin
                  rst_d[idx_q] = 1'b1;
                  cnt_d        = CntZero;
                  idx_d        = idx_q + IdxOne;
                  if (idx_q == IdxLast) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end

            ST_RUN: begin
               if (sw_rst_req_i) begin
                  done_d = 1'b0;
                  cnt_d  = CntZero;
`ifdef RST_SEQUENCER_REVERSE_ASSERT_EN
                  rst_d[NumDomains-1] = 1'b0;
                  if (NumDomains == 1) begin
                     state_d = ST_SW_HOLD;
                  end else begin
                     state_d = ST_SW_ASSERT;
                     idx_d   = IdxBelowTop;
                  end
`else
                  rst_d   = {NumDomains{1'b0}};
                  state_d = ST_SW_HOLD;
`endif
               end else begin
                  state_d = ST_RUN;
               end
            end

`ifdef RST_SEQUENCER_REVERSE_ASSERT_EN
            ST_SW_ASSERT: begin
               // idx_q is the next domain to put back into reset.
               if (cnt_q == DelayLast) begin
                  rst_d[idx_q] = 1'b0;
                  cnt_d        = CntZero;
                  if (idx_q == IdxZero) begin
                     state_d = ST_SW_HOLD;
                  end else begin
                     idx_d = idx_q - IdxOne;
                  end
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
`endif

            ST_SW_HOLD: begin
               if (cnt_q == HoldLast) begin
                  ack_d   = 1'b1;
                  cnt_d   = CntZero;
                  state_d = ST_SW_ACK;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end

            ST_SW_ACK: begin
               if (!sw_rst_req_i) begin
                  ack_d   = 1'b0;
                  cnt_d   = CntZero;
                  idx_d   = IdxZero;
                  state_d = ST_RELEASE;
               end else begin
                  state_d = ST_SW_ACK;
               end
            end

            default: begin
               state_d = ST_WAIT_INIT;
               cnt_d   = CntZero;
               idx_d   = IdxZero;
               rst_d   = {NumDomains{1'b0}};
               ack_d   = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // State and registered-output flops, cleared asynchronously by rst_ni.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_WAIT_INIT;
         cnt_q   <= CntZero;
         idx_q   <= IdxZero;
         rst_q   <= {NumDomains{1'b0}};
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   // Test mode hands every domain reset directly to rst_ni.
   assign rst_no       = test_mode_i ? {NumDomains{rst_ni}} : rst_q;
   assign sw_rst_ack_o = ack_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

   localparam int N = 4;
   localparam int D = 8;
   localparam int H = 16;

   // Reference-model phases (timeline view, not the DUT encoding).
   localparam int P_WAIT   = 0;
   localparam int P_REL    = 1;
   localparam int P_RUN    = 2;
   localparam int P_HOLD   = 3;
   localparam int P_ACK    = 4;
   localparam int P_ASSERT = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          init_ni;
   logic          test_mode_i;
   logic          sw_rst_req_i;
   logic          sw_rst_ack_o;
   logic [N-1:0]  rst_no;
   logic          done_o;

   int n_tests = 0;
   int n_fail  = 0;

   int phase;
   int t0;
   int cyc;

   always #5 clk_i = ~clk_i;

   rst_sequencer #(
      .NumDomains (N),
      .DelayCycles(D),
      .HoldCycles (H)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .init_ni     (init_ni),
      .test_mode_i (test_mode_i),
      .sw_rst_req_i(sw_rst_req_i),
      .sw_rst_ack_o(sw_rst_ack_o),
      .rst_no      (rst_no),
      .done_o      (done_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Expected domain resets from elapsed time in the current phase.
   function automatic logic [N-1:0] exp_rst();
      int k;
      case (phase)
         P_REL: begin
            k = (cyc - t0) / D;
            if (k > N) k = N;
            return N'((1 << k) - 1);
         end
         P_RUN:    return {N{1'b1}};
         P_ASSERT: begin
            k = 1 + (cyc - t0) / D;
            if (k > N) k = N;
            return N'((1 << (N - k)) - 1);
         end
         default:  return {N{1'b0}};
      endcase
   endfunction

   // Advance the reference timeline by one clock edge using pre-edge inputs.
   task automatic model_edge();
      cyc++;
      if (!rst_ni) begin
         phase = P_WAIT;
      end else if (phase != P_WAIT && !init_ni) begin
         phase = P_WAIT;
      end else begin
         case (phase)
            P_WAIT: if (init_ni) begin phase = P_REL; t0 = cyc; end
            P_REL:  if (cyc - t0 >= N * D) phase = P_RUN;
            P_RUN:  if (sw_rst_req_i) begin
`ifdef RST_SEQUENCER_REVERSE_ASSERT_EN
               phase = P_ASSERT;
`else
               phase = P_HOLD;
`endif
               t0 = cyc;
            end
            P_ASSERT: if (cyc - t0 >= (N - 1) * D) begin phase = P_HOLD; t0 = cyc; end
            P_HOLD:   if (cyc - t0 >= H) phase = P_ACK;
            P_ACK:    if (!sw_rst_req_i) begin phase = P_REL; t0 = cyc; end
            default:  phase = P_WAIT;
         endcase
      end
   endtask

   task automatic check_outputs(input string where);
      logic [N-1:0] e;
      e = test_mode_i ? {N{rst_ni}} : exp_rst();
      chk({where, "_rst_no"}, 32'(rst_no), 32'(e));
      chk({where, "_ack"},    32'(sw_rst_ack_o), 32'(phase == P_ACK));
      chk({where, "_done"},   32'(done_o), 32'(phase == P_RUN));
   endtask

   initial begin
      rst_ni       = 1'b0;
      init_ni      = 1'b1;
      test_mode_i  = 1'b0;
      sw_rst_req_i = 1'b0;
      phase        = P_WAIT;
      t0           = 0;
      cyc          = 0;

      #2;
      check_outputs("reset");
      repeat (2) begin
         @(posedge clk_i);
         model_edge();
         #1;
         check_outputs("in_reset");
      end
      rst_ni = 1'b1;

      for (int i = 0; i < 6000; i++) begin
         @(posedge clk_i);
         model_edge();
         #1;
         check_outputs("edge");

         // Random stimulus, biased so long sequences and handshakes complete.
         if (rst_ni && $urandom_range(0, 399) == 0) begin
            rst_ni = 1'b0;
            phase  = P_WAIT;
         end else if (!rst_ni && $urandom_range(0, 2) == 0) begin
            rst_ni = 1'b1;
         end
         if (init_ni && $urandom_range(0, 249) == 0) begin
            init_ni = 1'b0;
         end else if (!init_ni && $urandom_range(0, 3) == 0) begin
            init_ni = 1'b1;
         end
         if ($urandom_range(0, 24) == 0) sw_rst_req_i = ~sw_rst_req_i;
         if ($urandom_range(0, 99) == 0) test_mode_i = ~test_mode_i;

         #1;
         check_outputs("drive");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
